// File: rtl/clock_tap_tracker.sv
// Closed-loop phi0 delay-line tap controller: averages phase-difference samples and steps the tap.
// Optional build macro CLOCK_TAP_FAST_SLEW_EN enables a 4-tap step for large averaged errors.
module clock_tap_tracker #(
  parameter int TAP_BITS = 9,
  parameter int TAP_MIN  = 0,
  parameter int TAP_MAX  = 499,
  parameter int TAP_INIT = 50,
  parameter int TARGET   = 0,
  parameter int DEADBAND = 2,
  parameter int AVG_LOG2 = 3,
  parameter int SETTLE_N = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic                eclk,
  input  logic                ereset_n,
  input  logic                diff_valid,
  input  logic signed [15:0]  diff,
  input  logic                auto_en,
  input  logic                man_inc,
  input  logic                man_dec,
  output logic [TAP_BITS-1:0] tap,
  output logic                locked,
  output logic                at_limit,
  output logic                sig_lost
);

  // state  | meaning
  // IDLE   | manual mode, waiting for auto_en
  // ACCUM  | summing 2**AVG_LOG2 samples
  // DECIDE | one cycle: compare mean error, step tap
  // SETTLE | discarding SETTLE_N samples after a tap change
  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, SETTLE} state_t;

  localparam int N_AVG  = 1 << AVG_LOG2;
  localparam int ACC_W  = 16 + AVG_LOG2;
  localparam int ERR_W  = ACC_W + 2;
  localparam int TW     = TAP_BITS + 2;
  localparam int CNT_W  = ((AVG_LOG2 + 1) > $clog2(SETTLE_N + 1)) ? (AVG_LOG2 + 1)
                                                                  : $clog2(SETTLE_N + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic signed [TW-1:0]    MIN_S  = TW'(TAP_MIN);
  localparam logic signed [TW-1:0]    MAX_S  = TW'(TAP_MAX);
  localparam logic [TAP_BITS-1:0]     INIT_V = TAP_BITS'(TAP_INIT);
  localparam logic signed [ERR_W-1:0] TGT_S  = ERR_W'(TARGET);
  localparam logic signed [ERR_W-1:0] DB_S   = ERR_W'(DEADBAND);
  localparam logic [CNT_W-1:0]        AVG_LAST    = CNT_W'(N_AVG - 1);
  localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_N - 1);
  localparam logic [IDLE_W-1:0]       IDLE_LAST   = IDLE_W'(TIMEOUT - 1);

  state_t                    state, state_n;
  logic signed [ACC_W-1:0]   acc, acc_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDLE_W-1:0]         idle_cnt, idle_n;
  logic [TAP_BITS-1:0]       tap_q, tap_n;
  logic                      locked_q, locked_n;
  logic                      at_limit_q, at_limit_n;
  logic                      sig_lost_q, sig_lost_n;

  logic signed [ACC_W-1:0]   diff_ext;
  logic signed [ACC_W-1:0]   mean;
  logic signed [ERR_W-1:0]   err;
  logic signed [TW-1:0]      step;
  logic signed [TW-1:0]      delta;
  logic signed [TW-1:0]      cand;
  logic                      do_step;

  assign diff_ext = $signed({{AVG_LOG2{diff[15]}}, diff});
  assign mean     = acc >>> AVG_LOG2;
  assign err      = $signed({{2{mean[ACC_W-1]}}, mean}) - TGT_S;

`ifdef CLOCK_TAP_FAST_SLEW_EN
  // Large averaged errors take a coarse step to pull in faster.
  logic wide_err;
  assign wide_err = (err > (DB_S <<< 2)) || (err < -(DB_S <<< 2));
  assign step     = wide_err ? TW'(4) : TW'(1);
`else
  assign step     = TW'(1);
`endif

  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      idle_cnt   <= '0;
      tap_q      <= INIT_V;
      locked_q   <= 1'b0;
      at_limit_q <= 1'b0;
      sig_lost_q <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      idle_cnt   <= idle_n;
      tap_q      <= tap_n;
      locked_q   <= locked_n;
      at_limit_q <= at_limit_n;
      sig_lost_q <= sig_lost_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = cnt;
    idle_n     = idle_cnt;
    tap_n      = tap_q;
    locked_n   = locked_q;
    at_limit_n = at_limit_q;
    sig_lost_n = sig_lost_q;
    delta      = '0;
    do_step    = 1'b0;
    cand       = '0;

    if (diff_valid) sig_lost_n = 1'b0;

    if (!auto_en) begin
      state_n  = IDLE;
      acc_n    = '0;
      cnt_n    = '0;
      idle_n   = '0;
      locked_n = 1'b0;
      if (man_inc ^ man_dec) begin
        delta   = man_inc ? TW'(1) : -TW'(1);
        do_step = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state_n = ACCUM;
          acc_n   = '0;
          cnt_n   = '0;
          idle_n  = '0;
        end
        ACCUM: begin
          if (diff_valid) begin
            acc_n  = acc + diff_ext;
            idle_n = '0;
            if (cnt == AVG_LAST) begin
              state_n = DECIDE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            sig_lost_n = 1'b1;
            locked_n   = 1'b0;
            acc_n      = '0;
            cnt_n      = '0;
            idle_n     = '0;
          end else begin
            idle_n = idle_cnt + 1'b1;
          end
        end
        DECIDE: begin
          // Any strobe landing here is intentionally dropped.
          idle_n = '0;
          cnt_n  = '0;
          acc_n  = '0;
          if (err > DB_S) begin
            delta    = -step;
            do_step  = 1'b1;
            locked_n = 1'b0;
            state_n  = SETTLE;
          end else if (err < -DB_S) begin
            delta    = step;
            do_step  = 1'b1;
            locked_n = 1'b0;
            state_n  = SETTLE;
          end else begin
            locked_n = 1'b1;
            state_n  = ACCUM;
          end
        end
        SETTLE: begin
          if (diff_valid) begin
            idle_n = '0;
            if (cnt == SETTLE_LAST) begin
              state_n = ACCUM;
              acc_n   = '0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            sig_lost_n = 1'b1;
            locked_n   = 1'b0;
            state_n    = ACCUM;
            acc_n      = '0;
            cnt_n      = '0;
            idle_n     = '0;
          end else begin
            idle_n = idle_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Out-of-range candidate covers both overshoot and an already-pinned tap.
    if (do_step) begin
      cand = $signed({2'b00, tap_q}) + delta;
      if (cand < MIN_S) begin
        tap_n      = MIN_S[TAP_BITS-1:0];
        at_limit_n = 1'b1;
      end else if (cand > MAX_S) begin
        tap_n      = MAX_S[TAP_BITS-1:0];
        at_limit_n = 1'b1;
      end else begin
        tap_n      = cand[TAP_BITS-1:0];
        at_limit_n = 1'b0;
      end
    end
  end

  assign tap      = tap_q;
  assign locked   = locked_q;
  assign at_limit = at_limit_q;
  assign sig_lost = sig_lost_q;

endmodule

// File: tb/tb_clock_tap_tracker.sv
// Directed self-checking bench for clock_tap_tracker; expectations are hand-computed.
// Honours CLOCK_TAP_FAST_SLEW_EN for the coarse-step expectation.
module tb_clock_tap_tracker;

  logic               eclk = 1'b0;
  logic               ereset_n;
  logic               diff_valid;
  logic signed [15:0] diff;
  logic               auto_en;
  logic               man_inc;
  logic               man_dec;
  logic [8:0]         tap;
  logic               locked;
  logic               at_limit;
  logic               sig_lost;

  int n_cmp = 0;
  int n_err = 0;

  clock_tap_tracker dut (
    .eclk       (eclk),
    .ereset_n   (ereset_n),
    .diff_valid (diff_valid),
    .diff       (diff),
    .auto_en    (auto_en),
    .man_inc    (man_inc),
    .man_dec    (man_dec),
    .tap        (tap),
    .locked     (locked),
    .at_limit   (at_limit),
    .sig_lost   (sig_lost)
  );

  always #5 eclk = ~eclk;

  task automatic tick();
    @(posedge eclk);
    #1;
  endtask

  task automatic do_reset();
    ereset_n   = 1'b0;
    diff_valid = 1'b0;
    diff       = '0;
    auto_en    = 1'b0;
    man_inc    = 1'b0;
    man_dec    = 1'b0;
    tick();
    tick();
    ereset_n = 1'b1;
    tick();
  endtask

  task automatic send(input int v);
    diff       = 16'(v);
    diff_valid = 1'b1;
    tick();
    diff_valid = 1'b0;
    tick();
  endtask

  task automatic send_n(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic pulse(input logic inc, input logic dec);
    man_inc = inc;
    man_dec = dec;
    tick();
    man_inc = 1'b0;
    man_dec = 1'b0;
    tick();
  endtask

  task automatic go_auto();
    auto_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tap !== 9'd50) begin n_err++; $display("FAIL reset_tap got %0d want 50", tap); end
    n_cmp++; if ({locked, at_limit, sig_lost} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b want 000", {locked, at_limit, sig_lost}); end
    pulse(1'b1, 1'b0);
    n_cmp++; if (tap !== 9'd51) begin n_err++; $display("FAIL manual_inc got %0d want 51", tap); end
  endtask

  task automatic test_track_and_lock();
    do_reset();
    go_auto();
    send_n(10, 8);
    n_cmp++; if (tap !== 9'd49) begin n_err++; $display("FAIL track_step got %0d want 49", tap); end
    n_cmp++; if ({locked, at_limit} !== 2'b00) begin
      n_err++; $display("FAIL track_flags got %b want 00", {locked, at_limit}); end
    send_n(10, 4);
    n_cmp++; if (tap !== 9'd49) begin n_err++; $display("FAIL settle_ignored got %0d want 49", tap); end
    send_n(1, 8);
    n_cmp++; if ({locked, tap} !== {1'b1, 9'd49}) begin
      n_err++; $display("FAIL lock_small got locked=%b tap=%0d want 1/49", locked, tap); end
    for (int i = 0; i < 4; i++) begin
      send(-7);
      send(5);
    end
    n_cmp++; if ({locked, tap} !== {1'b1, 9'd49}) begin
      n_err++; $display("FAIL lock_alt got locked=%b tap=%0d want 1/49", locked, tap); end
    send_n(-3, 8);
    n_cmp++; if ({locked, tap} !== {1'b0, 9'd50}) begin
      n_err++; $display("FAIL neg_step got locked=%b tap=%0d want 0/50", locked, tap); end
  endtask

  task automatic test_limits();
    do_reset();
    for (int i = 0; i < 50; i++) pulse(1'b0, 1'b1);
    n_cmp++; if ({tap, at_limit} !== {9'd0, 1'b0}) begin
      n_err++; $display("FAIL dec_to_min got tap=%0d lim=%b want 0/0", tap, at_limit); end
    go_auto();
    send_n(20, 8);
    n_cmp++; if ({tap, at_limit} !== {9'd0, 1'b1}) begin
      n_err++; $display("FAIL auto_clamp_min got tap=%0d lim=%b want 0/1", tap, at_limit); end
    auto_en = 1'b0;
    tick();
    for (int i = 0; i < 499; i++) pulse(1'b1, 1'b0);
    n_cmp++; if ({tap, at_limit} !== {9'd499, 1'b0}) begin
      n_err++; $display("FAIL inc_to_max got tap=%0d lim=%b want 499/0", tap, at_limit); end
    pulse(1'b1, 1'b0);
    n_cmp++; if ({tap, at_limit} !== {9'd499, 1'b1}) begin
      n_err++; $display("FAIL clamp_max got tap=%0d lim=%b want 499/1", tap, at_limit); end
  endtask

  task automatic test_slew();
    logic [8:0] exp_tap;
`ifdef CLOCK_TAP_FAST_SLEW_EN
    exp_tap = 9'd46;
`else
    exp_tap = 9'd49;
`endif
    do_reset();
    go_auto();
    send_n(20, 8);
    n_cmp++; if (tap !== exp_tap) begin
      n_err++; $display("FAIL wide_err_step got %0d want %0d", tap, exp_tap); end
  endtask

  task automatic test_timeout_and_drop();
    do_reset();
    auto_en = 1'b1;
    repeat (65500) tick();
    n_cmp++; if (sig_lost !== 1'b0) begin n_err++; $display("FAIL early_timeout got %b want 0", sig_lost); end
    repeat (100) tick();
    n_cmp++; if (sig_lost !== 1'b1) begin n_err++; $display("FAIL timeout got %b want 1", sig_lost); end
    send(10);
    n_cmp++; if (sig_lost !== 1'b0) begin n_err++; $display("FAIL sig_lost_clear got %b want 0", sig_lost); end
    send_n(10, 2);
    auto_en = 1'b0;
    tick();
    tick();
    go_auto();
    send_n(10, 7);
    n_cmp++; if (tap !== 9'd50) begin n_err++; $display("FAIL stale_acc got %0d want 50", tap); end
    send(10);
    n_cmp++; if (tap !== 9'd49) begin n_err++; $display("FAIL fresh_eight got %0d want 49", tap); end
  endtask

  task automatic test_both_and_reset();
    do_reset();
    pulse(1'b1, 1'b1);
    n_cmp++; if (tap !== 9'd50) begin n_err++; $display("FAIL both_pulses got %0d want 50", tap); end
    go_auto();
    pulse(1'b1, 1'b0);
    n_cmp++; if (tap !== 9'd50) begin n_err++; $display("FAIL pulse_in_auto got %0d want 50", tap); end
    send_n(10, 8);
    send(10);
    #2 ereset_n = 1'b0;
    #1;
    n_cmp++; if ({tap, locked, at_limit, sig_lost} !== {9'd50, 3'b000}) begin
      n_err++; $display("FAIL async_reset got tap=%0d flags=%b want 50/000", tap, {locked, at_limit, sig_lost}); end
    #3 ereset_n = 1'b1;
    tick();
    tick();
    send_n(10, 8);
    n_cmp++; if (tap !== 9'd49) begin n_err++; $display("FAIL post_reset_idle got %0d want 49", tap); end
  endtask

  initial begin
    test_reset();
    test_track_and_lock();
    test_limits();
    test_slew();
    test_both_and_reset();
    test_timeout_and_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
